// File: rtl/pipe_fd_skid.sv
// Fetch/decode pipeline stage with a DEPTH-entry skid buffer between fetch and decode.
// Presents NOP_INSTR when empty and counts the bubble cycles decode receives.
module pipe_fd_skid #(
  parameter int unsigned PC_W = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'b0000100000000000,
  parameter int unsigned CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_W-1:0]              in_pc2,
  input  logic [INSTR_W-1:0]           in_instr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc2,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             bubble_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [PC_W-1:0]    pc2_mem_q   [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             push, pop, write_en;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_ready  = (count_q < FullCnt);
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    write_en  = push & ~flush;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    bubble_d = bubble_q;
    if (!out_valid && out_ready && (bubble_q != '1)) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      bubble_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      bubble_q <= bubble_d;
    end
  end

  // Entry storage is never cleared; only entries behind a nonzero count are ever shown.
  always_ff @(posedge clk) begin
    if (write_en) begin
      pc2_mem_q[wr_ptr_q]   <= in_pc2;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

  always_comb begin
    out_pc2    = out_valid ? pc2_mem_q[rd_ptr_q] : '0;
    out_instr  = out_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
    count      = count_q;
    bubble_cnt = bubble_q;
  end

endmodule

// File: doc/pipe_fd_skid.md
Name: pipe_fd_skid

Overview:
Parametrised IF/D pipeline stage that replaces the single-entry fetch/decode latch with a DEPTH-entry skid buffer. Fetch can keep delivering instructions for up to DEPTH cycles while decode stalls. Each entry holds a {PC+2, instruction} pair, presented to decode in order. The stage supplies a NOP whenever it is empty, on reset, and on flush, and keeps a saturating count of the bubble cycles it delivers.

Parameters:
PC_W, 16, width of the PC+2 field
INSTR_W, 16, width of the instruction field
DEPTH, 2, number of buffer entries; legal values 1..4 (1 reproduces a plain stalling latch)
NOP_INSTR, 16'b0000100000000000, instruction presented to decode when no valid entry exists (never all-zeroes, which decodes as HALT)
CNT_W, 8, width of the bubble counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous discard of all buffered entries (branch/jump redirect)
in_valid  in  1  fetch presents a valid pair this cycle
in_ready  out  1  stage can accept a pair this cycle
in_pc2  in  PC_W  PC+2 from fetch
in_instr  in  INSTR_W  instruction from fetch
out_valid  out  1  head entry valid toward decode
out_ready  in  1  decode consumes the head this cycle (decode not stalled)
out_pc2  out  PC_W  PC+2 of the head entry; 0 when out_valid=0
out_instr  out  INSTR_W  instruction of the head entry; NOP_INSTR when out_valid=0
count  out  clog2(DEPTH+1)  number of occupied entries
bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0 and out_ready=1

Behaviour:
- Storage: circular buffer with DEPTH entries, a read pointer (rd_ptr) and a write pointer (wr_ptr), each of clog2(DEPTH) bits, min 1. Both pointers wrap from DEPTH-1 to 0. For non-power-of-2 DEPTH, wrap is an explicit compare, not bit overflow.
- in_ready = (count < DEPTH). It is combinational from registered count only, with no path from out_ready.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- out_valid = (count != 0). The out_* fields are driven from entry[rd_ptr], or the NOP/0 values when count == 0. The decode view has zero added latency beyond the register.
- A pushed pair is visible on the outputs the cycle after the push edge (1-cycle latency, same as the original latch).
- Simultaneous push and pop: count is unchanged, both pointers advance. At count == DEPTH, in_ready = 0, so no push occurs even if a pop occurs that cycle.
- Pop with count == 0 has no effect. Push with in_ready = 0 is dropped; fetch must hold its data.
- Priority, highest first: rst, then flush, then push/pop.
- rst: count=0, rd_ptr=wr_ptr=0, bubble_cnt=0. From the next cycle, out_valid=0, out_instr=NOP_INSTR, out_pc2=0, in_ready=1. Entry contents need not be cleared.
- flush: count=0 and rd_ptr=wr_ptr=0 next cycle. Any push in the flush cycle is discarded. bubble_cnt is unaffected by flush. rst asserted mid-flush behaves as rst.
- bubble_cnt increments when out_valid=0 & out_ready=1 & !rst. It saturates at 2^CNT_W-1 and does not wrap.
- Invariants:
  - count <= DEPTH.
  - wr_ptr == (rd_ptr + count) mod DEPTH.
  - out_instr is never X after the first reset.

Test Plan:
- Reset (DEPTH=2): assert rst for 2 cycles -> out_valid=0, out_instr=16'h0800, out_pc2=0, count=0, in_ready=1, bubble_cnt=0.
- Streaming: push pc2=0x0002/instr=0x4A01, then 0x0004/0x4A02, with out_ready=1 every cycle -> decode sees 0x4A01 then 0x4A02 on consecutive cycles; count stays <=1.
- Stall fill: out_ready=0, push 3 pairs (0x1111, 0x2222, 0x3333) -> first two accepted; in_ready=0 at count=2; third held by fetch. Release out_ready -> order 0x1111, 0x2222, 0x3333; 0x3333 accepted the cycle after count drops to 1.
- Flush while full, with in_valid=1 carrying 0x5555 -> next cycle count=0, out_instr=0x0800; 0x5555 is never presented to decode.
- Wrap: DEPTH=3, 10 pairs with alternating out_ready -> output order matches input order across pointer wrap 2->0; count never exceeds 3.
- Bubble saturation: CNT_W=4, empty buffer, out_ready=1 for 20 cycles -> bubble_cnt reaches 15 and holds; rst returns it to 0.
